// File: rtl/music_box_pkg.sv
// music_box_pkg: shared sequencer state encoding, note ROM entry layout and song constants
package music_box_pkg;
  localparam int PERIOD_W    = 16;
  localparam int DURATION_W  = 10;
  localparam int END_OF_SONG = 0;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} seq_state_t;
  typedef struct packed {
    logic [PERIOD_W-1:0]   halfPeriod;
    logic [DURATION_W-1:0] duration;
  } note_t;
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: note ROM bus; master=sequencer (drives romAddr), slave=ROM (returns romData one cycle later)
interface note_sequencer_if #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 26
);
  logic [ADDR_BITS-1:0] romAddr;
  logic [DATA_BITS-1:0] romData;
  modport master (output romAddr, input romData);
  modport slave (input romAddr, output romData);
endinterface

// File: rtl/tick_edge_detect.sv
// tick_edge_detect: 2-flop synchronizer plus rising-edge pulse; ports inputClock, reset_n (async low), i_in (async level), o_pulse (one-cycle pulse)
module tick_edge_detect (
  input  logic inputClock,
  input  logic reset_n,
  input  logic i_in,
  output logic o_pulse
);
  logic [2:0] r_sync;
  always_ff @(posedge inputClock or negedge reset_n)
    if (!reset_n) r_sync <= '0;
    else r_sync <= {r_sync[1:0], i_in};
  assign o_pulse = r_sync[1] & ~r_sync[2];
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays {halfPeriod,duration} notes from a ROM as a square wave; ports inputClock, reset_n, tickClock, start, stop, rom (ROM bus), toneOut, playing, songDone
module note_sequencer
  import music_box_pkg::*;
#(
  parameter int ADDR_BITS     = 5,
  parameter int PERIOD_BITS   = 16,
  parameter int DURATION_BITS = 10,
  parameter int GAP_TICKS     = 20,
  parameter int LOOP          = 0
) (
  input  logic             inputClock,
  input  logic             reset_n,
  input  logic             tickClock,
  input  logic             start,
  input  logic             stop,
  note_sequencer_if.master rom,
  output logic             toneOut,
  output logic             playing,
  output logic             songDone
);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;
  seq_state_t r_state, w_state;
  logic [ADDR_BITS-1:0] r_addr, w_addr;
  logic [PERIOD_BITS-1:0] r_half, w_half, r_tone_cnt, w_tone_cnt, w_rom_half;
  logic [DURATION_BITS-1:0] r_dur, w_dur, r_gap, w_gap, w_rom_dur;
  logic r_tone, w_tone, r_playing, r_done, w_done;
  logic w_tick, w_wrap, w_song_end;
  tick_edge_detect u_tick (
    .inputClock(inputClock),
    .reset_n   (reset_n),
    .i_in      (tickClock),
    .o_pulse   (w_tick)
  );
  assign {w_rom_half, w_rom_dur} = rom.romData;
  assign w_wrap     = r_tone_cnt == r_half - 1'b1;
  assign w_song_end = (r_addr == LAST_ADDR) && (LOOP == 0);
  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_half     = r_half;
    w_tone_cnt = r_tone_cnt;
    w_dur      = r_dur;
    w_gap      = r_gap;
    w_tone     = 1'b0;
    w_done     = 1'b0;
    if (stop) w_state = IDLE;
    else if (start) begin
      w_state = FETCH;
      w_addr  = '0;
    end else
      case (r_state)
        FETCH: w_state = LOAD;
        LOAD: begin
          w_half     = w_rom_half;
          w_dur      = w_rom_dur;
          w_tone_cnt = '0;
          if (w_rom_dur == DURATION_BITS'(END_OF_SONG)) begin
            w_state = (LOOP != 0) ? FETCH : IDLE;
            w_done  = LOOP == 0;
            if (LOOP != 0) w_addr = '0;
          end else w_state = PLAY;
        end
        PLAY: begin
          // a zero halfPeriod is a rest: the divider still runs but the pin stays low
          w_tone_cnt = w_wrap ? '0 : r_tone_cnt + 1'b1;
          w_tone     = (r_half != '0) & (r_tone ^ w_wrap);
          if (w_tick) begin
            w_dur = r_dur - 1'b1;
            if (r_dur == DURATION_BITS'(1)) begin
              w_tone  = 1'b0;
              w_gap   = DURATION_BITS'(GAP_TICKS);
              w_state = GAP;
            end
          end
        end
        GAP:
          // leaving is decided on the cycle gapCnt is already 0, so GAP_TICKS=0 gives a one-cycle gap
          if (r_gap == '0) begin
            w_addr  = r_addr + 1'b1;
            w_state = w_song_end ? IDLE : FETCH;
            w_done  = w_song_end;
          end else if (w_tick) w_gap = r_gap - 1'b1;
        default: w_state = IDLE;
      endcase
  end
  always_ff @(posedge inputClock or negedge reset_n)
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_half     <= '0;
      r_tone_cnt <= '0;
      r_dur      <= '0;
      r_gap      <= '0;
      r_tone     <= 1'b0;
      r_playing  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_half     <= w_half;
      r_tone_cnt <= w_tone_cnt;
      r_dur      <= w_dur;
      r_gap      <= w_gap;
      r_tone     <= w_tone;
      r_playing  <= w_state != IDLE;
      r_done     <= w_done;
    end
  assign rom.romAddr = r_addr;
  assign toneOut     = r_tone;
  assign playing     = r_playing;
  assign songDone    = r_done;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: drives a LOOP=0 and a LOOP=1 sequencer from one ROM image and checks both against a per-note timing model
module tb_note_sequencer;
  import music_box_pkg::*;
  localparam int AB = 5, PB = 16, DB = 10, GT = 2, N = 32;
  localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2, M_PLAY = 3, M_GAP = 4;
  logic inputClock = 1'b0, reset_n = 1'b1, tickClock = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] tone_v, play_v, done_v;
  logic [AB-1:0] addr_v [2];
  note_t rom [N];
  int checks = 0, failures = 0;
  int done_cnt [2] = '{0, 0};
  int wrap_cnt = 0;
  logic [AB-1:0] prev_addr1 = '0;
  int m_ph [2] = '{0, 0};
  int m_addr [2] = '{0, 0};
  int m_half [2] = '{0, 0};
  int m_left [2] = '{0, 0};
  int m_e [2] = '{0, 0};
  int m_gap [2] = '{0, 0};
  bit m_done [2] = '{0, 0};
  bit p1 = 0, p2 = 0, p3 = 0;
  for (genvar g = 0; g < 2; g++) begin : u
    note_sequencer_if #(.ADDR_BITS(AB), .DATA_BITS(PB + DB)) rom_if ();
    note_sequencer #(
      .ADDR_BITS(AB), .PERIOD_BITS(PB), .DURATION_BITS(DB), .GAP_TICKS(GT), .LOOP(g)
    ) dut (
      .inputClock(inputClock),
      .reset_n   (reset_n),
      .tickClock (tickClock),
      .start     (start),
      .stop      (stop),
      .rom       (rom_if.master),
      .toneOut   (tone_v[g]),
      .playing   (play_v[g]),
      .songDone  (done_v[g])
    );
    always @(posedge inputClock) rom_if.romData <= rom[rom_if.romAddr];
    assign addr_v[g] = rom_if.romAddr;
  end
  initial forever #5 inputClock = ~inputClock;
  initial begin
    #2;
    forever #100 tickClock = ~tickClock;
  end
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic bit m_tone(int i);
    return m_ph[i] == M_PLAY && m_half[i] != 0 && ((m_e[i] / m_half[i]) % 2 == 1);
  endfunction
  task automatic model_step(int i, bit tk);
    m_done[i] = 0;
    if (stop) m_ph[i] = M_IDLE;
    else if (start) begin
      m_ph[i]   = M_FETCH;
      m_addr[i] = 0;
    end else
      case (m_ph[i])
        M_FETCH: m_ph[i] = M_LOAD;
        M_LOAD:
          if (rom[m_addr[i]].duration == 0) begin
            if (i == 1) begin
              m_addr[i] = 0;
              m_ph[i]   = M_FETCH;
            end else begin
              m_ph[i]   = M_IDLE;
              m_done[i] = 1;
            end
          end else begin
            m_half[i] = int'(rom[m_addr[i]].halfPeriod);
            m_left[i] = int'(rom[m_addr[i]].duration);
            m_e[i]    = 0;
            m_ph[i]   = M_PLAY;
          end
        M_PLAY: begin
          m_e[i]++;
          if (tk) begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_gap[i] = GT;
              m_ph[i]  = M_GAP;
            end
          end
        end
        M_GAP:
          if (m_gap[i] == 0) begin
            m_addr[i] = (m_addr[i] + 1) % N;
            if (m_addr[i] == 0 && i == 0) begin
              m_ph[i]   = M_IDLE;
              m_done[i] = 1;
            end else m_ph[i] = M_FETCH;
          end else if (tk) m_gap[i]--;
        default: ;
      endcase
  endtask
  always @(posedge inputClock or negedge reset_n) begin
    bit tk;
    if (!reset_n) begin
      p1 = 0; p2 = 0; p3 = 0;
      for (int i = 0; i < 2; i++) begin
        m_ph[i] = M_IDLE; m_addr[i] = 0; m_half[i] = 0; m_left[i] = 0;
        m_e[i] = 0; m_gap[i] = 0; m_done[i] = 0;
      end
    end else begin
      // a tickClock rise seen at one edge takes effect two edges later
      tk = p2 && !p3;
      p3 = p2; p2 = p1; p1 = tickClock;
      for (int i = 0; i < 2; i++) model_step(i, tk);
    end
  end
  always @(negedge inputClock) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("romAddr%0d", i), 32'(addr_v[i]), m_addr[i]);
      check($sformatf("toneOut%0d", i), 32'(tone_v[i]), 32'(m_tone(i)));
      check($sformatf("playing%0d", i), 32'(play_v[i]), 32'(m_ph[i] != M_IDLE));
      check($sformatf("songDone%0d", i), 32'(done_v[i]), 32'(m_done[i]));
      done_cnt[i] += int'(done_v[i]);
    end
    if (play_v[1] && prev_addr1 == 5'd31 && addr_v[1] == 5'd0) wrap_cnt++;
    prev_addr1 <= addr_v[1];
  end
  task automatic cycles(int n);
    repeat (n) @(negedge inputClock);
  endtask
  task automatic pulse(bit s, bit t);
    @(negedge inputClock);
    start = s; stop = t;
    @(negedge inputClock);
    start = 0; stop = 0;
  endtask
  task automatic wait_idle0(string tag, int budget);
    int k = 0;
    while (play_v[0] && k < budget) begin
      @(negedge inputClock);
      k++;
    end
    check(tag, 32'(play_v[0]), 0);
  endtask
  task automatic wait_addr0(string tag, int a, int budget);
    int k = 0;
    while (int'(addr_v[0]) != a && k < budget) begin
      @(negedge inputClock);
      k++;
    end
    check(tag, 32'(addr_v[0]), a);
  endtask
  task automatic clear_rom();
    for (int j = 0; j < N; j++) rom[j] = '0;
  endtask
  initial begin
    int base0, base1, wbase;
    clear_rom();
    reset_n = 1'b0;
    cycles(3);
    check("reset_playing", 32'(play_v), 0);
    check("reset_addr", 32'(addr_v[0]), 0);
    reset_n = 1'b1;
    cycles(4);
    // single note then end marker
    rom[0] = '{16'd5, 10'd3};
    rom[1] = '{16'($urandom_range(1, 9)), 10'd0};
    base0 = done_cnt[0];
    pulse(1, 0);
    wait_idle0("t1_idle", 400);
    cycles(2);
    check("t1_done_once", done_cnt[0] - base0, 1);
    pulse(0, 1);
    // rest note followed by a tone
    clear_rom();
    rom[0] = '{16'd0, 10'd2};
    rom[1] = '{16'($urandom_range(1, 7)), 10'd1};
    pulse(1, 0);
    wait_addr0("t2_advance", 1, 300);
    wait_idle0("t2_idle", 300);
    pulse(0, 1);
    // stop mid-note, then restart
    clear_rom();
    for (int j = 0; j < 4; j++) rom[j] = '{16'($urandom_range(1, 9)), 10'($urandom_range(2, 3))};
    base0 = done_cnt[0];
    pulse(1, 0);
    cycles(11);
    pulse(0, 1);
    check("t3_playing", 32'(play_v), 0);
    check("t3_tone", 32'(tone_v), 0);
    check("t3_no_done", done_cnt[0] - base0, 0);
    pulse(1, 0);
    cycles(3);
    check("t3_restart_addr", 32'(addr_v[0]), 0);
    check("t3_restart_play", 32'(play_v[0]), 1);
    // start and stop together
    cycles(9);
    pulse(1, 1);
    check("t4_stop_wins", 32'(play_v), 0);
    // full 32-entry song
    for (int j = 0; j < N; j++) rom[j] = '{16'($urandom_range(0, 9)), 10'($urandom_range(1, 2))};
    base0 = done_cnt[0]; base1 = done_cnt[1]; wbase = wrap_cnt;
    pulse(1, 0);
    wait_idle0("t5_idle", 6000);
    cycles(4);
    check("t5_done0", done_cnt[0] - base0, 1);
    check("t5_done1", done_cnt[1] - base1, 0);
    check("t5_wrap1", wrap_cnt - wbase, 1);
    check("t5_loop_playing", 32'(play_v[1]), 1);
    pulse(0, 1);
    // asynchronous reset mid-note
    clear_rom();
    rom[0] = '{16'd3, 10'd1};
    rom[1] = '{16'd4, 10'd10};
    pulse(1, 0);
    wait_addr0("t6_addr1", 1, 300);
    cycles(40);
    @(posedge inputClock);
    #2 reset_n = 1'b0;
    #1;
    check("t6_tone", 32'(tone_v), 0);
    check("t6_playing", 32'(play_v), 0);
    check("t6_addr0", 32'(addr_v[0]), 0);
    check("t6_addr1r", 32'(addr_v[1]), 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
